// File: rtl/cpu_defs.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// State, request bundle and divide-by-zero constant.
package cpu_defs;

    localparam int MD_MODE_W = 2;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        MD_IDLE,
        MD_MBUSY,
        MD_DBUSY,
        MD_DONE,
        MD_DRAIN
    } muldiv_state_t;

    typedef struct packed {
        logic                 sign;
        logic [MD_MODE_W-1:0] mode;
        logic [31:0]          a;
        logic [31:0]          b;
        logic [31:0]          hi;
        logic [31:0]          lo;
    } muldiv_req_t;

endpackage

// File: rtl/muldiv_watchdog.sv
// Saturating cycle counter that flags a unit which never answers.
// Clear has priority over enable; the count stops at TIMEOUT.
module muldiv_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer between EX and the multi-cycle multiplier/divider units:
// latches operands, launches one unit, stalls EX and holds the result.
module muldiv_seq
    import cpu_defs::*;
#(
    parameter int MODE_W  = MD_MODE_W,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_mul,
    input  logic              req_div,
    input  logic              mul_sign,
    input  logic              div_sign,
    input  logic [MODE_W-1:0] mul_mode,
    input  logic [31:0]       srca,
    input  logic [31:0]       srcb,
    input  logic [31:0]       in_hi,
    input  logic [31:0]       in_lo,
    input  logic              advance,
    input  logic              flush,
    output logic              mul_in_valid,
    output logic              div_in_valid,
    output logic              op_sign,
    output logic [MODE_W-1:0] op_mode,
    output logic [31:0]       op_a,
    output logic [31:0]       op_b,
    output logic [31:0]       op_hi,
    output logic [31:0]       op_lo,
    input  logic              mul_out_valid,
    input  logic [31:0]       mul_hi,
    input  logic [31:0]       mul_lo,
    input  logic              div_out_valid,
    input  logic [31:0]       div_hi,
    input  logic [31:0]       div_lo,
    output logic              busy,
    output logic              res_valid,
    output logic [31:0]       res_hi,
    output logic [31:0]       res_lo,
    output logic              timeout_err
);

    muldiv_state_t r_state;
    muldiv_req_t   r_req;
    logic          r_sel_div;
    logic          r_mul_iv;
    logic          r_div_iv;
    logic          r_tout;
    logic [31:0]   r_res_hi;
    logic [31:0]   r_res_lo;

    logic          w_req;
    logic          w_pick_div;
    logic          w_div0;
    logic          w_sel_ov;
    logic [31:0]   w_sel_hi;
    logic [31:0]   w_sel_lo;
    logic          w_take;
    logic          w_wd_en;
    logic          w_expired;
    muldiv_req_t   w_new;

    assign w_req      = req_mul | req_div;
    assign w_pick_div = req_div & ~req_mul;
    assign w_div0     = w_pick_div & (srcb == 32'd0);

    assign w_sel_ov = r_sel_div ? div_out_valid : mul_out_valid;
    assign w_sel_hi = r_sel_div ? div_hi : mul_hi;
    assign w_sel_lo = r_sel_div ? div_lo : mul_lo;

    // A drained unit frees the slot, so a waiting op launches straight away.
    assign w_take = w_req & ~flush &
                    ((r_state == MD_IDLE) |
                     ((r_state == MD_DRAIN) & w_sel_ov));

    assign w_wd_en = (r_state == MD_MBUSY) |
                     (r_state == MD_DBUSY) |
                     (r_state == MD_DRAIN);

    assign w_new = '{
        sign: w_pick_div ? div_sign : mul_sign,
        mode: mul_mode,
        a:    srca,
        b:    srcb,
        hi:   in_hi,
        lo:   in_lo
    };

    muldiv_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wd (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_take),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= MD_IDLE;
            r_req     <= '0;
            r_sel_div <= 1'b0;
            r_mul_iv  <= 1'b0;
            r_div_iv  <= 1'b0;
            r_tout    <= 1'b0;
            r_res_hi  <= '0;
            r_res_lo  <= '0;
        end else begin
            r_mul_iv <= 1'b0;
            r_div_iv <= 1'b0;
            r_tout   <= 1'b0;
            if (w_take) begin
                if (w_div0) begin
                    r_state  <= MD_DONE;
                    r_res_hi <= srca;
                    r_res_lo <= DIV0_LO;
                end else begin
                    r_req     <= w_new;
                    r_sel_div <= w_pick_div;
                    r_mul_iv  <= ~w_pick_div;
                    r_div_iv  <= w_pick_div;
                    r_state   <= w_pick_div ? MD_DBUSY : MD_MBUSY;
                end
            end else begin
                unique case (r_state)
                    MD_MBUSY, MD_DBUSY: begin
                        if (flush) begin
                            r_state <= w_sel_ov ? MD_IDLE : MD_DRAIN;
                        end else if (w_sel_ov) begin
                            r_state  <= MD_DONE;
                            r_res_hi <= w_sel_hi;
                            r_res_lo <= w_sel_lo;
                        end else if (w_expired) begin
                            r_state  <= MD_DONE;
                            r_res_hi <= '0;
                            r_res_lo <= '0;
                            r_tout   <= 1'b1;
                        end
                    end
                    MD_DRAIN: begin
                        if (w_sel_ov) begin
                            r_state <= MD_IDLE;
                        end else if (w_expired) begin
                            r_state <= MD_IDLE;
                            r_tout  <= 1'b1;
                        end
                    end
                    MD_DONE: begin
                        if (advance | flush) begin
                            r_state <= MD_IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign busy = rst & (((r_state == MD_IDLE) & w_req & ~flush) |
                         (r_state == MD_MBUSY) |
                         (r_state == MD_DBUSY) |
                         ((r_state == MD_DRAIN) & w_req));

    assign mul_in_valid = r_mul_iv;
    assign div_in_valid = r_div_iv;
    assign op_sign      = r_req.sign;
    assign op_mode      = r_req.mode;
    assign op_a         = r_req.a;
    assign op_b         = r_req.b;
    assign op_hi        = r_req.hi;
    assign op_lo        = r_req.lo;
    assign res_valid    = (r_state == MD_DONE);
    assign res_hi       = r_res_hi;
    assign res_lo       = r_res_lo;
    assign timeout_err  = r_tout;

endmodule
